logdrop_window_accum: RTL and testbench

- Sequential, multi-channel successor to the combinational logdrop window function.
- Accepts a stream of N_CHANNEL samples and weights each sample by its position in a fixed-length window: either rectangular (weight 1) or logdrop (right-shift by floor(log2(age+1))).
- Accumulates one sum per channel per window.
- Presents completed window sums through a one-entry valid/ready result buffer. Sits between sample sources and the correlation/statistics logic downstream.

---
 rtl/logdrop_window_accum_pkg.sv | 22 ++
 rtl/logdrop_weight.sv | 40 ++++
 rtl/logdrop_window_accum.sv | 120 ++++++++++++
 tb/tb_logdrop_window_accum.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logdrop_window_accum_pkg.sv
// Shared constants and width helpers for the windowed logdrop accumulator.
// Mode encodings, a constant-foldable clog2, and the sum-width derivation.
package logdrop_window_accum_pkg;

  localparam logic MODE_RECT    = 1'b0;
  localparam logic MODE_LOGDROP = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // A full window of maximal samples needs clog2(WINLEN) extra bits.
  function automatic int sumWidth(input int dataW, input int winLen);
    return dataW + clog2(winLen);
  endfunction

endpackage

// File: rtl/logdrop_weight.sv
// Combinational per-sample weight: passes x through (rectangular) or shifts it
// right by floor(log2(age+1)) with age = WINLEN-1-t (logdrop).
module logdrop_weight
  import logdrop_window_accum_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WINLEN = 64,
  localparam int T_W   = clog2(WINLEN),
  localparam int SUM_W = sumWidth(DATA_W, WINLEN),
  localparam int SH_W  = clog2(T_W + 1)
) (
  input  logic [T_W-1:0]    t,
  input  logic              mode,
  input  logic [DATA_W-1:0] x,
  output logic [SUM_W-1:0]  weighted
);

  logic [T_W:0]    span;
  logic [SH_W-1:0] shift;

  // span = age + 1 = WINLEN - t, always in 1..WINLEN
  assign span = (T_W + 1)'(WINLEN) - {1'b0, t};

  always_comb begin
    shift = '0;
    for (int b = 0; b <= T_W; b++) begin
      if (span[b]) begin
        shift = SH_W'(b);
      end
    end
  end

  always_comb begin
    weighted = SUM_W'(x);
    if (mode == MODE_LOGDROP) begin
      weighted = SUM_W'(x) >> shift;
    end
  end

endmodule

// File: rtl/logdrop_window_accum.sv
// Multi-channel windowed accumulator: weights each accepted sample by its window
// position and hands completed per-channel sums to a one-entry result buffer.
module logdrop_window_accum
  import logdrop_window_accum_pkg::*;
#(
  parameter int N_CHANNEL = 4,
  parameter int DATA_W    = 8,
  parameter int WINLEN    = 64,
  localparam int T_W      = clog2(WINLEN),
  localparam int SUM_W    = sumWidth(DATA_W, WINLEN)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_cg,
  input  logic                          i_clear,
  input  logic                          i_mode,
  input  logic                          i_valid,
  input  logic [N_CHANNEL*DATA_W-1:0]   i_x,
  output logic [T_W-1:0]                o_t,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [N_CHANNEL*SUM_W-1:0]    o_sum,
  output logic                          o_mode,
  output logic                          o_drop
);

  logic [T_W-1:0] tReg;
  logic           modeReg;
  logic           validReg;
  logic           modeOutReg;
  logic           dropReg;

  logic accept;
  logic windowStart;
  logic effMode;
  logic lastSample;
  logic bufFree;
  logic loadResult;
  logic consume;
  logic clearNow;

  assign accept      = i_cg && i_valid && !i_clear;
  assign windowStart = (tReg == '0);
  // The first sample of a window sees i_mode before it has been latched.
  assign effMode     = windowStart ? i_mode : modeReg;
  assign lastSample  = accept && (tReg == T_W'(WINLEN - 1));
  assign bufFree     = !validReg || i_ready;
  assign loadResult  = lastSample && bufFree;
  assign consume     = i_cg && validReg && i_ready;
  assign clearNow    = i_cg && i_clear;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tReg       <= '0;
      modeReg    <= MODE_RECT;
      validReg   <= 1'b0;
      modeOutReg <= MODE_RECT;
      dropReg    <= 1'b0;
    end else begin
      // Drop pulse is recomputed every cycle, so it never outlives one cycle.
      dropReg <= lastSample && !bufFree;
      if (clearNow) begin
        tReg <= '0;
      end else if (accept) begin
        tReg <= tReg + T_W'(1);
      end
      if (accept && windowStart) begin
        modeReg <= i_mode;
      end
      if (loadResult) begin
        validReg   <= 1'b1;
        modeOutReg <= effMode;
      end else if (consume) begin
        validReg <= 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_CHANNEL; gi++) begin : gChan
      logic [SUM_W-1:0] contrib;
      logic [SUM_W-1:0] accReg;
      logic [SUM_W-1:0] sumReg;

      logdrop_weight #(
        .DATA_W (DATA_W),
        .WINLEN (WINLEN)
      ) uWeight (
        .t        (tReg),
        .mode     (effMode),
        .x        (i_x[gi*DATA_W +: DATA_W]),
        .weighted (contrib)
      );

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          accReg <= '0;
          sumReg <= '0;
        end else begin
          if (clearNow || lastSample) begin
            accReg <= '0;
          end else if (accept) begin
            accReg <= accReg + contrib;
          end
          if (loadResult) begin
            sumReg <= accReg + contrib;
          end
        end
      end

      assign o_sum[gi*SUM_W +: SUM_W] = sumReg;
    end
  endgenerate

  assign o_t     = tReg;
  assign o_valid = validReg;
  assign o_mode  = modeOutReg;
  assign o_drop  = dropReg;

endmodule

// File: tb/tb_logdrop_window_accum.sv
// Directed plus randomized bench for logdrop_window_accum; expected values come
// from a window-level model that stores the samples and sums them at completion.
module tb_logdrop_window_accum;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int WIN = 64;
  localparam int TW  = 6;
  localparam int SW  = DW + TW;

  logic                i_clk;
  logic                i_rst;
  logic                i_cg;
  logic                i_clear;
  logic                i_mode;
  logic                i_valid;
  logic [NCH*DW-1:0]   i_x;
  logic [TW-1:0]       o_t;
  logic                o_valid;
  logic                i_ready;
  logic [NCH*SW-1:0]   o_sum;
  logic                o_mode;
  logic                o_drop;

  logdrop_window_accum #(
    .N_CHANNEL (NCH),
    .DATA_W    (DW),
    .WINLEN    (WIN)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_cg    (i_cg),
    .i_clear (i_clear),
    .i_mode  (i_mode),
    .i_valid (i_valid),
    .i_x     (i_x),
    .o_t     (o_t),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
    .o_mode  (o_mode),
    .o_drop  (o_drop)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model state
  int                mT;
  bit                mLatched;
  bit                mValid;
  bit                mOMode;
  bit                mDrop;
  logic [NCH*SW-1:0] mSum;
  logic [NCH*DW-1:0] winQ[$];
  int                checks;
  int                errors;

  function automatic int shiftOf(input int t);
    int v;
    int s;
    v = WIN - t;
    s = 0;
    while (v > 1) begin
      v = v / 2;
      s++;
    end
    return s;
  endfunction

  function automatic logic [NCH*SW-1:0] windowSum(input bit md);
    logic [NCH*SW-1:0] r;
    logic [NCH*DW-1:0] smp;
    int                s;
    int                xv;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      s = 0;
      for (int i = 0; i < winQ.size(); i++) begin
        smp = winQ[i];
        xv  = int'(smp[c*DW +: DW]);
        s  += md ? (xv >> shiftOf(i)) : xv;
      end
      r[c*SW +: SW] = s[SW-1:0];
    end
    return r;
  endfunction

  task automatic modelReset();
    mT       = 0;
    mLatched = 1'b0;
    mValid   = 1'b0;
    mOMode   = 1'b0;
    mDrop    = 1'b0;
    mSum     = '0;
    winQ.delete();
  endtask

  task automatic modelEdge(input bit v, input bit cl, input bit rd, input bit cg,
                           input bit md, input logic [NCH*DW-1:0] x);
    bit consume;
    mDrop = 1'b0;
    if (cg) begin
      consume = mValid && rd;
      if (cl) begin
        mT = 0;
        winQ.delete();
      end else if (v) begin
        if (mT == 0) mLatched = md;
        winQ.push_back(x);
        if (mT == WIN - 1) begin
          if (!mValid || rd) begin
            mSum    = windowSum(mLatched);
            mOMode  = mLatched;
            mValid  = 1'b1;
            consume = 1'b0;
          end else begin
            mDrop = 1'b1;
          end
          winQ.delete();
          mT = 0;
        end else begin
          mT++;
        end
      end
      if (consume) mValid = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    logic [TW-1:0] expT;
    expT = mT[TW-1:0];
    check("o_t", 64'(o_t), 64'(expT));
    check("o_valid", 64'(o_valid), 64'(mValid));
    check("o_mode", 64'(o_mode), 64'(mOMode));
    check("o_drop", 64'(o_drop), 64'(mDrop));
    check("o_sum", 64'(o_sum), 64'(mSum));
  endtask

  task automatic step(input bit v, input bit cl, input bit rd, input bit cg,
                      input bit md, input logic [NCH*DW-1:0] x);
    i_valid = v;
    i_clear = cl;
    i_ready = rd;
    i_cg    = cg;
    i_mode  = md;
    i_x     = x;
    modelEdge(v, cl, rd, cg, md, x);
    @(posedge i_clk);
    #1;
    checkAll();
    $display("step v=%0b clr=%0b rdy=%0b cg=%0b md=%0b x=%h | t=%0d valid=%0b mode=%0b drop=%0b sum=%h",
             v, cl, rd, cg, md, x, o_t, o_valid, o_mode, o_drop, o_sum);
  endtask

  task automatic fullWindow(input bit md, input bit rd);
    for (int i = 0; i < WIN; i++) step(1'b1, 1'b0, rd, 1'b1, md, $urandom);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    i_rst   = 1'b1;
    i_cg    = 1'b0;
    i_clear = 1'b0;
    i_mode  = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_x     = '0;
    modelReset();
    #2;
    checkAll();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);

    // Rectangular window: ch0=0xFF, ch1=0x01
    for (int i = 0; i < WIN; i++) begin
      logic [NCH*DW-1:0] x;
      x = $urandom;
      x[15:0] = 16'h01FF;
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, x);
    end
    check("rect_valid", 64'(o_valid), 64'd1);
    check("rect_ch0", 64'(o_sum[0 +: SW]), 64'h3FC0);
    check("rect_ch1", 64'(o_sum[SW +: SW]), 64'h0040);
    check("rect_mode", 64'(o_mode), 64'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("rect_consumed", 64'(o_valid), 64'd0);

    // Logdrop window of 0xFF on every channel
    for (int i = 0; i < WIN; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, {NCH{8'hFF}});
    for (int c = 0; c < NCH; c++) check("logdrop_sum", 64'(o_sum[c*SW +: SW]), 64'd1476);
    check("logdrop_mode", 64'(o_mode), 64'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);

    // Backpressure: second window is dropped
    for (int i = 0; i < WIN; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {NCH{8'h01}});
    for (int i = 0; i < WIN; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {NCH{8'h02}});
    check("bp_drop", 64'(o_drop), 64'd1);
    check("bp_held", 64'(o_sum[0 +: SW]), 64'h0040);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("bp_drop_end", 64'(o_drop), 64'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("bp_release", 64'(o_valid), 64'd0);
    check("bp_sum_kept", 64'(o_sum[SW +: SW]), 64'h0040);

    // Clear at t=30, then a window whose mode toggles at t=10
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, $urandom);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, $urandom);
    check("clear_t", 64'(o_t), 64'd0);
    check("clear_valid", 64'(o_valid), 64'd0);
    for (int i = 0; i < WIN; i++) step(1'b1, 1'b0, 1'b1, 1'b1, (i < 10), $urandom);
    check("latched_mode", 64'(o_mode), 64'd1);

    // Async reset mid-window with a pending result
    fullWindow(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, $urandom);
    #2 i_rst = 1'b1;
    #1;
    check("arst_valid", 64'(o_valid), 64'd0);
    check("arst_t", 64'(o_t), 64'd0);
    check("arst_sum", 64'(o_sum), 64'd0);
    modelReset();
    #1 i_rst = 1'b0;
    fullWindow(1'b1, 1'b1);

    // Clock gate low: nothing moves, nothing consumed
    fullWindow(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, $urandom);
    check("cg_valid", 64'(o_valid), 64'd1);
    check("cg_t", 64'(o_t), 64'd5);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 4) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
